// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage sequencer in front of the combinational ALU.
// Accepts one 16-bit instruction at a time, feeds ALU operands from an 8x8
// register file, captures the result and writes it back three cycles after
// acceptance. Holds the architectural flag register {cr, ov, ng, zr}.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_valid, instr    instruction handshake input (16-bit word)
//   instr_ready           high only while IDLE
//   done                  one-cycle pulse during the writeback cycle
//   alu_a, alu_b          regfile[IR.rs1], regfile[IR.rs2]
//   alu_op, alu_shamt     IR.opcode, {2'b00, IR.shamt}
//   alu_out, alu_cr/ov/ng/zr   ALU result and flags
//   flags                 {cr, ov, ng, zr} flag register
//   dbg_addr, dbg_data    combinational register-file read port
//   dbg_state             current FSM state (0 IDLE, 1 EXEC, 2 WB)
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready is low in EXEC and WB, so upstream
// must hold instr_valid/instr until the transfer edge; instr_valid seen while
// busy has no effect.
module alu_exec_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic        done,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic [4:0]  alu_shamt,
  input  logic [7:0]  alu_out,
  input  logic        alu_cr,
  input  logic        alu_ov,
  input  logic        alu_ng,
  input  logic        alu_zr,
  output logic [3:0]  flags,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;

  state_e      state_q;
  logic [15:0] ir_q;
  logic [7:0]  rf_q [8];
  logic [7:0]  result_q;
  logic [3:0]  nflags_q;  // ALU flags captured in EXEC, applied in WB
  logic [3:0]  flags_q;
  logic        ready_q;
  logic        done_q;

  // Instruction decode from the latched IR
  logic [3:0] op;
  logic [2:0] rd;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic       is_ldi;
  logic       is_nop;
  logic       is_alu;
  logic       is_arith;

  assign op       = ir_q[15:12];
  assign rd       = ir_q[11:9];
  assign rs1      = ir_q[8:6];
  assign rs2      = ir_q[5:3];
  assign is_ldi   = (op == OP_LDI);
  assign is_nop   = (op >= 4'b1011) && (op <= 4'b1110);
  assign is_alu   = !is_ldi && !is_nop;
  assign is_arith = (op == OP_ADD) || (op == OP_SUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      result_q <= '0;
      nflags_q <= '0;
      flags_q  <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid && ready_q) begin
            ir_q    <= instr;
            ready_q <= 1'b0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q <= is_ldi ? ir_q[7:0] : alu_out;
          nflags_q <= {alu_cr, alu_ov, alu_ng, alu_zr};
          done_q   <= 1'b1;
          state_q  <= S_WB;
        end
        S_WB: begin
          if (!is_nop) rf_q[rd] <= result_q;
          // ADD/SUB own all four flags; other ALU ops only ng/zr.
          if (is_arith)    flags_q        <= nflags_q;
          else if (is_alu) flags_q[1:0]   <= nflags_q[1:0];
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign done        = done_q;
  assign alu_a       = rf_q[rs1];
  assign alu_b       = rf_q[rs2];
  assign alu_op      = op;
  assign alu_shamt   = {2'b00, ir_q[2:0]};
  assign flags       = flags_q;
  assign dbg_data    = rf_q[dbg_addr];
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: a stand-in ALU, a reference model of the
// architectural state (register file + flags), a driver issuing directed and
// random instructions, and a monitor that checks every writeback.
module tb_alu_exec_ctrl;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_LS  = 4'b0011;
  localparam logic [3:0] OP_SRS = 4'b0100;
  localparam logic [3:0] OP_URS = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_RRO = 4'b1000;
  localparam logic [3:0] OP_LRO = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        instr_ready;
  logic        done;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic [7:0]  alu_out;
  logic        alu_cr, alu_ov, alu_ng, alu_zr;
  logic [3:0]  flags;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic [1:0]  dbg_state;

  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .done(done),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_out(alu_out), .alu_cr(alu_cr), .alu_ov(alu_ov), .alu_ng(alu_ng), .alu_zr(alu_zr),
    .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // ---------------- stand-in ALU ----------------
  // Returns {out[7:0], cr, ov, ng, zr}. Non-arithmetic ops report operand
  // parities on cr/ov so any wrongful cr/ov update is visible; LDI/NOP
  // return ~a so a wrongful use of alu_out is visible.
  function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [2:0] sh);
    logic [8:0] w;
    logic [7:0] o;
    logic cr, ov;
    w = 9'd0; o = ~a; cr = ^a; ov = ^b;
    case (op)
      OP_ADD: begin w = {1'b0, a} + {1'b0, b}; o = w[7:0]; cr = w[8];
                    ov = (a[7] == b[7]) && (o[7] != a[7]); end
      OP_SUB: begin w = {1'b0, a} - {1'b0, b}; o = w[7:0]; cr = w[8];
                    ov = (a[7] != b[7]) && (o[7] != a[7]); end
      OP_AND: o = a & b;
      OP_OR:  o = a | b;
      OP_NOT: o = ~a;
      OP_SLT: o = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      OP_LS:  o = a << sh;
      OP_URS: o = a >> sh;
      OP_SRS: o = $signed(a) >>> sh;
      OP_RRO: o = (a >> sh) | (a << (4'd8 - {1'b0, sh}));
      OP_LRO: o = (a << sh) | (a >> (4'd8 - {1'b0, sh}));
      default: o = ~a;
    endcase
    return {o, cr, ov, o[7], (o == 8'd0)};
  endfunction

  always_comb begin
    {alu_out, alu_cr, alu_ov, alu_ng, alu_zr} = alu_f(alu_op, alu_a, alu_b, alu_shamt[2:0]);
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Entry: {a[30:23], b[22:15], rd[14:12], reg value after wb[11:4], flags[3:0]}
  logic [7:0]  m_rf [8];
  logic [3:0]  m_fl;
  logic [30:0] exp_q[$];
  int          acc_q[$];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    m_fl = 4'b0000;
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic model_push(input logic [15:0] w, input int acc);
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [7:0]  a, b;
    logic [11:0] r;
    op = w[15:12]; rd = w[11:9];
    a = m_rf[w[8:6]]; b = m_rf[w[5:3]];
    r = alu_f(op, a, b, w[2:0]);
    if (op == OP_LDI) begin
      m_rf[rd] = w[7:0];
    end else if (op >= 4'b1011 && op <= 4'b1110) begin
      // NOP: architectural state untouched
    end else begin
      m_rf[rd] = r[11:4];
      if (op == OP_ADD || op == OP_SUB) m_fl = r[3:0];
      else m_fl[1:0] = r[1:0];
    end
    exp_q.push_back({a, b, rd, m_rf[rd], m_fl});
    acc_q.push_back(acc);
  endtask

  // ---------------- monitor ----------------
  logic        chk_pend = 1'b0;
  logic [2:0]  mon_rd = 3'd0;
  logic [2:0]  probe_addr = 3'd0;
  logic [30:0] cur;
  int          cur_acc;

  assign dbg_addr = chk_pend ? mon_rd : probe_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk_pend = 1'b0;
    end else begin
      if (chk_pend) begin
        check("wb_reg", dbg_data, cur[11:4]);
        check("wb_flags", flags, cur[3:0]);
        check("ready_after_wb", instr_ready, 1);
        chk_pend = 1'b0;
      end
      if (acc_q.size() > 0 && cyc == acc_q[0] + 1) begin
        check("exec_alu_a", alu_a, exp_q[0][30:23]);
        check("exec_alu_b", alu_b, exp_q[0][22:15]);
        check("exec_ready_low", instr_ready, 0);
        check("exec_done_low", done, 0);
      end
      if (done) begin
        check("done_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          cur_acc = acc_q.pop_front();
          check("done_latency", cyc - cur_acc, 2);
          check("wb_ready_low", instr_ready, 0);
          mon_rd = cur[14:12];
          chk_pend = 1'b1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [2:0] sh);
    return {op, rd, rs1, rs2, sh};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {OP_LDI, rd, 1'b0, imm};
  endfunction

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Presents w (valid stays high afterwards); returns in the EXEC cycle.
  task automatic send(input logic [15:0] w, output int acc);
    bit ok;
    ok = 0; acc = -1;
    instr_valid = 1'b1;
    instr = w;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready) begin
        acc = cyc; ok = 1;
        model_push(w, cyc);
        break;
      end
      @(negedge clk);
    end
    check("accept_timeout", ok, 1);
    if (ok) @(negedge clk);
  endtask

  task automatic probe(input logic [2:0] r, input logic [7:0] v, input logic [3:0] f,
                       input string nm);
    idle(3);
    probe_addr = r;
    #1;
    check({nm, "_reg"}, dbg_data, v);
    check({nm, "_flags"}, flags, f);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0, a1, a2;
    model_reset();
    repeat (3) @(negedge clk);
    probe_addr = 3'd0;
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_done", done, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_shamt", alu_shamt, 0);
    check("rst_flags", flags, 0);
    check("rst_r0", dbg_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-EXEC aborts the instruction
    send(ldi(3'd1, 8'h55), a0);
    probe(3'd1, 8'h55, 4'b0000, "ldi_r1");
    @(negedge clk);
    send(mk(OP_ADD, 3'd3, 3'd1, 3'd1, 3'd0), a0);
    #2 rst_n = 1'b0;
    instr_valid = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done_after", done, 0);
    end
    probe_addr = 3'd1;
    #1;
    check("abort_r1", dbg_data, 8'h00);
    check("abort_r3", dut.rf_q[3], 8'h00);
    check("abort_flags", flags, 4'b0000);
    check("abort_ready", instr_ready, 1);
    @(negedge clk);

    // LDI then dependent ADD
    send(ldi(3'd1, 8'h7F), a0);
    send(ldi(3'd2, 8'h01), a0);
    send(mk(OP_ADD, 3'd3, 3'd1, 3'd2, 3'd0), a0);
    probe(3'd3, 8'h80, 4'b0110, "add_ovf");
    @(negedge clk);

    // Handshake hold: valid held high across three instructions
    send(ldi(3'd5, 8'h01), a0);
    send(ldi(3'd6, 8'h02), a1);
    send(ldi(3'd7, 8'h00), a2);
    check("hold_gap1", a1 - a0, 3);
    check("hold_gap2", a2 - a1, 3);

    // Flag retention: SUB borrows, AND gives zero and keeps cr/ov
    send(mk(OP_SUB, 3'd4, 3'd5, 3'd6, 3'd0), a0);
    probe(3'd4, 8'hFF, 4'b1010, "sub_borrow");
    @(negedge clk);
    send(mk(OP_AND, 3'd4, 3'd5, 3'd7, 3'd0), a0);
    probe(3'd4, 8'h00, 4'b1001, "and_keep_cr");
    @(negedge clk);

    // NOP targeting r3
    send(mk(4'b1100, 3'd3, 3'd1, 3'd2, 3'd0), a0);
    probe(3'd3, 8'h80, 4'b1001, "nop");
    @(negedge clk);

    // Self-modifying ADD
    send(ldi(3'd2, 8'h03), a0);
    send(mk(OP_ADD, 3'd2, 3'd2, 3'd2, 3'd0), a0);
    probe(3'd2, 8'h06, 4'b0000, "self_add");
    @(negedge clk);

    // Random instruction stream with random idle gaps
    for (int n = 0; n < 200; n++) begin
      send(16'($urandom), a0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(6);
    check("queue_drained", exp_q.size(), 0);
    for (int r = 0; r < 8; r++) begin
      probe_addr = 3'(r);
      #1;
      check("final_reg", dbg_data, m_rf[r]);
    end
    check("final_flags", flags, m_fl);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d failures=%0d)",
             checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execute-stage sequencer that sits directly upstream of the combinational ALU in the 8-bit microprocessor. It accepts 16-bit instructions over a valid/ready handshake, reads operands from an internal 8×8-bit register file, drives the ALU operand and opcode ports, and writes the ALU result back. It also holds the architectural flag register (carry, overflow, negative, zero). A 3-state FSM gives a fixed 3-cycle latency per instruction; there is no pipelining.

## Interface
- No parameters; data width 8, register count 8, instruction width 16 are fixed.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- instr_valid  input  1  upstream presents an instruction.
- instr  input  16  instruction word.
  - [15:12] opcode. [11:9] rd. [8:6] rs1. [5:3] rs2. [2:0] shamt.
  - For LDI: [7:0] is the immediate.
- instr_ready  output  1  block can accept; high only in IDLE.
- done  output  1  one-cycle pulse in the writeback cycle.
- alu_a  output  8  regfile[IR.rs1].
- alu_b  output  8  regfile[IR.rs2].
- alu_op  output  4  IR.opcode.
- alu_shamt  output  5  {2'b00, IR.shamt}.
- alu_out  input  8  ALU result.
- alu_cr, alu_ov, alu_ng, alu_zr  input  1 each  ALU flags.
- flags  output  4  {cr, ov, ng, zr} flag register.
- dbg_addr  input  3  debug read index.
- dbg_data  output  8  regfile[dbg_addr]; combinational read.

## Operation
- Opcodes:
  - ALU ops: ADD 0010, SUB 0110, AND 0000, OR 0001, NOT 1111, SLT 0111, LS 0011, URS 0101, SRS 0100, RRO 1000, LRO 1001.
  - LDI 1010.
  - NOP: 1011, 1100, 1101, 1110.
- FSM states: IDLE, EXEC, WB.
  - IDLE → EXEC on instr_valid && instr_ready; instr is latched into the 16-bit IR on that edge.
  - EXEC → WB unconditionally. On this edge:
    - result register ← alu_out, or IR[7:0] for LDI.
    - next-flags ← ALU flags.
  - WB → IDLE unconditionally. done = 1 throughout WB.
    - ALU op or LDI: the write to regfile[rd] occurs on the WB→IDLE edge.
    - Flag-register updates also occur on that edge; the rules are below.
- Flag rules:
  - ADD/SUB update all four flags.
  - All other ALU ops update ng and zr only; cr and ov hold.
  - LDI and NOP leave all flags unchanged.
- NOP: no register write, no flag change. Handshake and done still occur.
- alu_* outputs are driven from IR and the register file in every state. The ALU result is consumed only on the EXEC→WB edge.
- All registers, including r0, are general-purpose and writable.
- rd may equal rs1 or rs2. Operands are read in EXEC and the write happens at the end of WB, so no hazard is possible.
- instr_valid while not in IDLE is ignored; instr_ready is low, so upstream must hold the instruction.

## Timing
- Accept edge E0. EXEC is cycle 1. WB is cycle 2 with done = 1. Regfile and flags are visible from cycle 3.
- instr_ready is high again in cycle 3. Maximum throughput is 1 instruction per 3 cycles.
- Back-to-back dependent instructions need no stall: the second is read in its own EXEC, after the first's write.
- Reset values, applied asynchronously on rst_n low:
  - state = IDLE, IR = 0, all 8 registers = 0, result = 0, flags = 4'b0000.
  - Therefore done = 0, instr_ready = 1, alu_op = 0000, alu_a = alu_b = 0, alu_shamt = 0.
- Reset asserted in EXEC or WB aborts the instruction: no register write, no flag update, no done pulse.
- rst_n deassertion takes effect on the next rising clk edge. An instruction presented in that cycle is accepted at that edge.
- dbg_data reflects a write starting in the cycle after the write edge.

## Test plan
- Reset mid-EXEC:
  - Stimulus: LDI r1=0x55, then assert rst_n low during the next instruction's EXEC.
  - Required: r1 = 0x00, flags = 0000, instr_ready = 1, no done pulse.
- LDI then ADD:
  - Stimulus: LDI r1=0x7F, LDI r2=0x01, ADD r3=r1+r2 (ALU model returns 0x80, cr=0, ov=1, ng=1, zr=0).
  - Required: r3 = 0x80; flags = 0110; done pulses exactly once per instruction, 2 cycles after each accept.
- Handshake hold:
  - Stimulus: hold instr_valid high continuously with 3 instructions queued.
  - Required: accepts are exactly 3 cycles apart; instr_ready is low in EXEC and WB.
- Flag retention:
  - Stimulus: SUB yielding cr=1, then AND with result 0x00.
  - Required: flags = {1, prev ov, 0, 1}, i.e. cr is retained and zr is set.
- NOP:
  - Stimulus: opcode 1100 with rd=r3.
  - Required: r3 and flags unchanged; done pulses once.
- Self-modify:
  - Stimulus: ADD r2=r2+r2 with r2=0x03.
  - Required: r2 = 0x06. alu_a = alu_b = 0x03 during EXEC.
